// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants and ALU operation codes for the issue stage and the ALU.
package riscv_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_SR  = 3'b101;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000,
      ALU_SUB = 4'b0001,
      ALU_AND = 4'b0010,
      ALU_OR  = 4'b0011,
      ALU_XOR = 4'b0100,
      ALU_SLL = 4'b0101,
      ALU_SRL = 4'b0110
   } alu_op_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of R-type, OP-IMM and LUI words into ALU control and operands.
module alu_op_decode
   import riscv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic [31:0]       instr,
   input  logic [XLEN-1:0]   rs1_data,
   input  logic [XLEN-1:0]   rs2_data,
   output logic [3:0]        alu_ctrl,
   output logic [XLEN-1:0]   alu_a,
   output logic [XLEN-1:0]   alu_b,
   output logic [REG_AW-1:0] rd,
   output logic              wb_en,
   output logic              illegal
);

   logic [6:0] opc;
   logic [6:0] f7;
   logic [2:0] f3;
   alu_op_e    op;
   logic       legal;

   always_comb begin
      opc   = instr[6:0];
      f3    = instr[14:12];
      f7    = instr[31:25];
      op    = ALU_ADD;
      legal = 1'b0;
      alu_a = rs1_data;
      alu_b = rs2_data;
      case (opc)
         OPC_OP: begin
            if (f7 == F7_BASE) begin
               legal = 1'b1;
               case (f3)
                  F3_ADD:  op = ALU_ADD;
                  F3_SLL:  op = ALU_SLL;
                  F3_XOR:  op = ALU_XOR;
                  F3_SR:   op = ALU_SRL;
                  F3_OR:   op = ALU_OR;
                  F3_AND:  op = ALU_AND;
                  default: legal = 1'b0;
               endcase
            end else if (f7 == F7_ALT && f3 == F3_ADD) begin
               op    = ALU_SUB;
               legal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            alu_b = XLEN'(signed'(instr[31:20]));
            legal = 1'b1;
            case (f3)
               F3_ADD: op = ALU_ADD;
               F3_XOR: op = ALU_XOR;
               F3_OR:  op = ALU_OR;
               F3_AND: op = ALU_AND;
               F3_SLL, F3_SR: begin
                  // shifts take a zero-extended shamt; funct7 must be clear (srai unsupported)
                  op    = (f3 == F3_SLL) ? ALU_SLL : ALU_SRL;
                  alu_b = XLEN'(instr[24:20]);
                  legal = (f7 == F7_BASE);
               end
               default: legal = 1'b0;
            endcase
         end
         OPC_LUI: begin
            alu_a = '0;
            alu_b = XLEN'(signed'({instr[31:12], 12'b0}));
            legal = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      alu_ctrl = legal ? op : ALU_ADD;
      illegal  = !legal;
      rd       = instr[7 +: REG_AW];
      wb_en    = legal && (rd != '0);
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: decodes ALU ops and registers them towards EX behind a valid/ready skid buffer.
module alu_issue_stage
   import riscv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instr,
   input  logic [XLEN-1:0]   rs1_data,
   input  logic [XLEN-1:0]   rs2_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        alu_ctrl,
   output logic [XLEN-1:0]   alu_a,
   output logic [XLEN-1:0]   alu_b,
   output logic [REG_AW-1:0] rd,
   output logic              wb_en,
   output logic              illegal
);

   logic [3:0]        dec_ctrl;
   logic [XLEN-1:0]   dec_a;
   logic [XLEN-1:0]   dec_b;
   logic [REG_AW-1:0] dec_rd;
   logic              dec_wb;
   logic              dec_ill;

   logic              skid_valid;
   logic [3:0]        skid_ctrl;
   logic [XLEN-1:0]   skid_a;
   logic [XLEN-1:0]   skid_b;
   logic [REG_AW-1:0] skid_rd;
   logic              skid_wb;
   logic              skid_ill;

   alu_op_decode #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
   ) u_decode (
      .instr    (instr),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .alu_ctrl (dec_ctrl),
      .alu_a    (dec_a),
      .alu_b    (dec_b),
      .rd       (dec_rd),
      .wb_en    (dec_wb),
      .illegal  (dec_ill)
   );

   // Main register drives the outputs directly; skid catches the one beat accepted while main stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b0;
         alu_ctrl   <= ALU_ADD;
         alu_a      <= '0;
         alu_b      <= '0;
         rd         <= '0;
         wb_en      <= 1'b0;
         illegal    <= 1'b0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
      end else begin
         in_ready <= 1'b1;
         if (skid_valid) begin
            if (out_ready) begin
               alu_ctrl   <= skid_ctrl;
               alu_a      <= skid_a;
               alu_b      <= skid_b;
               rd         <= skid_rd;
               wb_en      <= skid_wb;
               illegal    <= skid_ill;
               skid_valid <= 1'b0;
            end else begin
               in_ready <= 1'b0;
            end
         end else if (in_valid && in_ready) begin
            if (!out_valid || out_ready) begin
               alu_ctrl  <= dec_ctrl;
               alu_a     <= dec_a;
               alu_b     <= dec_b;
               rd        <= dec_rd;
               wb_en     <= dec_wb;
               illegal   <= dec_ill;
               out_valid <= 1'b1;
            end else begin
               skid_ctrl  <= dec_ctrl;
               skid_a     <= dec_a;
               skid_b     <= dec_b;
               skid_rd    <= dec_rd;
               skid_wb    <= dec_wb;
               skid_ill   <= dec_ill;
               skid_valid <= 1'b1;
               in_ready   <= 1'b0;
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed vector table plus handshake sequences (stall, flush, reset) against alu_issue_stage.
module tb_alu_issue_stage;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        wb;
      logic        ill;
      logic        chk;
   } vec_t;

   localparam int NV = 24;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instr = '0;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  alu_ctrl;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [4:0]  rd;
   logic        wb_en;
   logic        illegal;

   vec_t vt[NV];
   int   sb[$];
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   alu_issue_stage #(
      .XLEN   (32),
      .REG_AW (5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_ctrl  (alu_ctrl),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .rd        (rd),
      .wb_en     (wb_en),
      .illegal   (illegal)
   );

   function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] r2, logic [4:0] r1,
                                         logic [2:0] f3, logic [4:0] rdi);
      return {f7, r2, r1, f3, rdi, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] r1, logic [2:0] f3,
                                         logic [4:0] rdi);
      return {imm, r1, f3, rdi, 7'b0010011};
   endfunction

   function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rdi);
      return {imm, rdi, 7'b0110111};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic cmp_beat(input string tag, input int idx);
      chk({tag, "_ctrl"}, 32'(alu_ctrl), 32'(vt[idx].ctrl));
      chk({tag, "_wb"}, 32'(wb_en), 32'(vt[idx].wb));
      chk({tag, "_ill"}, 32'(illegal), 32'(vt[idx].ill));
      if (vt[idx].chk) begin
         chk({tag, "_a"}, alu_a, vt[idx].a);
         chk({tag, "_b"}, alu_b, vt[idx].b);
         chk({tag, "_rd"}, 32'(rd), 32'(vt[idx].rd));
      end
   endtask

   // One cycle: drive at negedge, score the output transfer / stall, track accepted beats.
   task automatic step(input logic iv, input int idx, input logic ordy, input logic fl);
      @(negedge clk);
      in_valid  = iv;
      instr     = vt[idx].instr;
      rs1_data  = vt[idx].rs1;
      rs2_data  = vt[idx].rs2;
      out_ready = ordy;
      flush     = fl;
      if (fl) begin
         sb.delete();
      end else begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat got ctrl=%h a=%h exp none", alu_ctrl, alu_a);
            end else if (ordy) begin
               cmp_beat("beat", sb.pop_front());
            end else begin
               cmp_beat("hold", sb[0]);
            end
         end
         if (iv && in_ready) sb.push_back(idx);
      end
   endtask

   task automatic expect_empty(input string name);
      chk(name, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      vt[0]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 32'd5, 32'd7, 4'h0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1'b1};
      vt[1]  = '{enc_i(12'hFFF, 5'd0, 3'd0, 5'd1), 32'd0, 32'h55, 4'h0, 32'd0, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0, 1'b1};
      vt[2]  = '{enc_i(12'h004, 5'd2, 3'd5, 5'd2), 32'h80, 32'h99, 4'h6, 32'h80, 32'd4, 5'd2, 1'b1, 1'b0, 1'b1};
      vt[3]  = '{enc_u(20'h12345, 5'd5), 32'hDEAD, 32'hBEEF, 4'h0, 32'd0, 32'h12345000, 5'd5, 1'b1, 1'b0, 1'b1};
      vt[4]  = '{enc_i(12'h403, 5'd1, 3'd5, 5'd1), 32'd1, 32'd2, 4'h0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0};
      vt[5]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd4), 32'd1, 32'd2, 4'h0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0};
      vt[6]  = '{32'h00208463, 32'd1, 32'd2, 4'h0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0};
      vt[7]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 32'd9, 32'd4, 4'h0, 32'd9, 32'd4, 5'd0, 1'b0, 1'b0, 1'b1};
      vt[8]  = '{enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd7), 32'd10, 32'd3, 4'h1, 32'd10, 32'd3, 5'd7, 1'b1, 1'b0, 1'b1};
      vt[9]  = '{enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd8), 32'hF0F0, 32'hFF00, 4'h2, 32'hF0F0, 32'hFF00, 5'd8, 1'b1, 1'b0, 1'b1};
      vt[10] = '{enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd9), 32'd1, 32'd2, 4'h3, 32'd1, 32'd2, 5'd9, 1'b1, 1'b0, 1'b1};
      vt[11] = '{enc_r(7'h00, 5'd2, 5'd1, 3'd4, 5'd10), 32'd3, 32'd5, 4'h4, 32'd3, 32'd5, 5'd10, 1'b1, 1'b0, 1'b1};
      vt[12] = '{enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd11), 32'd1, 32'd3, 4'h5, 32'd1, 32'd3, 5'd11, 1'b1, 1'b0, 1'b1};
      vt[13] = '{enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd12), 32'h100, 32'd4, 4'h6, 32'h100, 32'd4, 5'd12, 1'b1, 1'b0, 1'b1};
      vt[14] = '{enc_i(12'hFF0, 5'd1, 3'd7, 5'd13), 32'h1234, 32'd0, 4'h2, 32'h1234, 32'hFFFFFFF0, 5'd13, 1'b1, 1'b0, 1'b1};
      vt[15] = '{enc_i(12'h7FF, 5'd1, 3'd6, 5'd14), 32'd0, 32'd0, 4'h3, 32'd0, 32'h7FF, 5'd14, 1'b1, 1'b0, 1'b1};
      vt[16] = '{enc_i(12'h800, 5'd1, 3'd4, 5'd15), 32'hAAAA, 32'd0, 4'h4, 32'hAAAA, 32'hFFFFF800, 5'd15, 1'b1, 1'b0, 1'b1};
      vt[17] = '{enc_i(12'h01F, 5'd3, 3'd1, 5'd3), 32'd1, 32'd0, 4'h5, 32'd1, 32'd31, 5'd3, 1'b1, 1'b0, 1'b1};
      vt[18] = '{enc_i(12'h021, 5'd3, 3'd1, 5'd3), 32'd1, 32'd0, 4'h0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0};
      vt[19] = '{enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd3), 32'd6, 32'd7, 4'h0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0};
      vt[20] = '{enc_r(7'h20, 5'd2, 5'd1, 3'd1, 5'd3), 32'd6, 32'd7, 4'h0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0};
      vt[21] = '{enc_i(12'h005, 5'd2, 3'd0, 5'd31), 32'hFFFFFFFF, 32'd0, 4'h0, 32'hFFFFFFFF, 32'd5, 5'd31, 1'b1, 1'b0, 1'b1};
      vt[22] = '{enc_i(12'h001, 5'd1, 3'd3, 5'd2), 32'd1, 32'd0, 4'h0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0};
      vt[23] = '{32'h00000000, 32'd1, 32'd2, 4'h0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0};

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_ctrl", 32'(alu_ctrl), 32'd0);
      chk("rst_a", alu_a, 32'd0);
      chk("rst_b", alu_b, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // table back-to-back with EX always ready: no bubbles, one-cycle latency
      for (int i = 0; i < NV; i++) step(1'b1, i, 1'b1, 1'b0);
      step(1'b0, 0, 1'b1, 1'b0);
      expect_empty("table_drain");
      step(1'b0, 0, 1'b1, 1'b0);

      // 4 beats back-to-back, EX stalled 3 cycles
      step(1'b1, 0, 1'b0, 1'b0);
      step(1'b1, 3, 1'b0, 1'b0);
      step(1'b1, 8, 1'b0, 1'b0);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_held", 32'(sb.size()), 32'd2);
      step(1'b1, 8, 1'b1, 1'b0);
      step(1'b1, 8, 1'b1, 1'b0);
      step(1'b1, 14, 1'b1, 1'b0);
      step(1'b0, 0, 1'b1, 1'b0);
      step(1'b0, 0, 1'b1, 1'b0);
      expect_empty("stall_drain");

      // flush with main+skid full, same-cycle beat dropped
      step(1'b1, 2, 1'b0, 1'b0);
      step(1'b1, 9, 1'b0, 1'b0);
      step(1'b1, 11, 1'b0, 1'b1);
      step(1'b0, 0, 1'b1, 1'b0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      step(1'b1, 16, 1'b1, 1'b0);
      step(1'b0, 0, 1'b1, 1'b0);
      step(1'b0, 0, 1'b1, 1'b0);
      expect_empty("flush_drain");

      // reset mid-stream
      step(1'b1, 12, 1'b1, 1'b0);
      step(1'b1, 13, 1'b0, 1'b0);
      chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      sb.delete();
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_ctrl", 32'(alu_ctrl), 32'd0);
      chk("mid_rst_a", alu_a, 32'd0);
      chk("mid_rst_b", alu_b, 32'd0);
      chk("mid_rst_rd", 32'(rd), 32'd0);
      chk("mid_rst_wb", 32'(wb_en), 32'd0);
      chk("mid_rst_ill", 32'(illegal), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("after_rst_in_ready", 32'(in_ready), 32'd1);
      chk("after_rst_out_valid", 32'(out_valid), 32'd0);

      // random valid/ready traffic drawn from the table
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 9) < 7, int'($urandom_range(0, NV - 1)),
              $urandom_range(0, 9) < 6, 1'b0);
      end
      repeat (4) step(1'b0, 0, 1'b1, 1'b0);
      expect_empty("random_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
